// File: rtl/bus_master_pkg.sv
// Shared definitions for the serial bus master: command encodings, FSM states,
// default widths and a small width helper.
package bus_master_pkg;

  localparam int DEF_ADDR_LEN  = 12;
  localparam int DEF_DATA_LEN  = 8;
  localparam int DEF_BURST_LEN = 12;
  localparam int DEF_SLAVE_LEN = 2;

  localparam logic [1:0] INSTR_WRITE = 2'b10;
  localparam logic [1:0] INSTR_READ  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_SEL,
    S_WAIT_ADDR,
    S_ADDR,
    S_WAIT_W,
    S_WDATA,
    S_RDATA,
    S_DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bus_master_in.sv
// Read-side deserializer: shifts rx_data in MSB first on every slave_valid
// while enabled and publishes each completed word with a one-cycle new_rx.
module bus_master_in
  import bus_master_pkg::*;
#(
  parameter int DATA_LEN = DEF_DATA_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                slave_valid,
  input  logic                rx_data,
  output logic                master_ready,
  output logic                word_done,
  output logic                new_rx,
  output logic [DATA_LEN-1:0] read_data
);

  localparam int CNT_W = $clog2(DATA_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LEN - 1);

  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_LEN-1:0] shift_q;
  logic [DATA_LEN-1:0] shift_next;
  logic                take_bit;

  assign master_ready = enable;
  assign take_bit     = enable && slave_valid;
  assign shift_next   = {shift_q[DATA_LEN-2:0], rx_data};
  // Combinational strobe so the FSM can stop requesting bits right after the last one.
  assign word_done    = take_bit && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      shift_q   <= '0;
      new_rx    <= 1'b0;
      read_data <= '0;
    end else begin
      new_rx <= 1'b0;
      if (take_bit) begin
        shift_q <= shift_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt   <= '0;
          read_data <= shift_next;
          new_rx    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_master.sv
// Serial bus master: latches a switch command, arbitrates for the bus, then
// serially sends select/address/burst and streams write data or collects reads.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int ADDR_LEN  = DEF_ADDR_LEN,
  parameter int DATA_LEN  = DEF_DATA_LEN,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int SLAVE_LEN = DEF_SLAVE_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_LEN-1:0]  address,
  input  logic [DATA_LEN-1:0]  data,
  input  logic [BURST_LEN-1:0] burst_num,
  input  logic [SLAVE_LEN-1:0] slave_select,
  input  logic [1:0]           instruction,
  input  logic                 approval_grant,
  input  logic                 busy,
  input  logic                 slave_ready,
  input  logic                 slave_valid,
  input  logic                 rx_data,
  output logic                 approval_request,
  output logic                 tx_slave_select,
  output logic                 tx_address,
  output logic                 tx_burst_number,
  output logic                 tx_data,
  output logic                 master_valid,
  output logic                 master_ready,
  output logic                 tx_done,
  output logic                 write_en,
  output logic                 read_en,
  output logic                 new_rx,
  output logic [DATA_LEN-1:0]  read_data
);

  localparam int CNT_W = $clog2(max3(ADDR_LEN, DATA_LEN, SLAVE_LEN)) + 1;
  localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(SLAVE_LEN - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);

  state_t               state, state_next;
  logic                 op_write_q;
  logic [SLAVE_LEN-1:0] sel_sh;
  logic [ADDR_LEN-1:0]  addr_sh;
  logic [BURST_LEN-1:0] burst_q;
  logic [BURST_LEN-1:0] burst_sh;
  logic [DATA_LEN-1:0]  data_q;
  logic [DATA_LEN-1:0]  data_sh;
  logic [CNT_W-1:0]     bit_cnt;
  // One bit wider than burst_num so an all-ones burst counts 2^BURST_LEN words.
  logic [BURST_LEN:0]   word_cnt;
  logic [BURST_LEN:0]   words_total;
  logic                 last_word;
  logic                 rd_enable;
  logic                 rd_word_done;

  assign words_total = {1'b0, burst_q} + 1'b1;
  assign last_word   = (word_cnt + 1'b1) == words_total;
  assign rd_enable   = (state == S_RDATA) && (word_cnt != words_total);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first; any path leaving state_next unassigned would infer a latch.
    state_next = state;
    case (state)
      S_IDLE:      if (instruction[1]) state_next = S_REQ;
      S_REQ:       if (approval_grant && !busy) state_next = S_SEL;
      S_SEL:       if (bit_cnt == SEL_LAST) state_next = S_WAIT_ADDR;
      S_WAIT_ADDR: if (slave_ready) state_next = S_ADDR;
      S_ADDR:      if (bit_cnt == ADDR_LAST) state_next = op_write_q ? S_WAIT_W : S_RDATA;
      S_WAIT_W:    if (slave_ready) state_next = S_WDATA;
      S_WDATA:     if (bit_cnt == DATA_LAST) state_next = last_word ? S_DONE : S_WAIT_W;
      S_RDATA:     if (new_rx && word_cnt == words_total) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Command latch, serial shifters and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_write_q <= 1'b0;
      sel_sh     <= '0;
      addr_sh    <= '0;
      burst_q    <= '0;
      burst_sh   <= '0;
      data_q     <= '0;
      data_sh    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (instruction[1]) begin
          op_write_q <= (instruction == INSTR_WRITE);
          sel_sh     <= slave_select;
          addr_sh    <= address;
          burst_q    <= burst_num;
          burst_sh   <= burst_num;
          data_q     <= data;
          bit_cnt    <= '0;
          word_cnt   <= '0;
        end
        S_SEL: begin
          sel_sh  <= sel_sh << 1;
          bit_cnt <= (bit_cnt == SEL_LAST) ? '0 : bit_cnt + 1'b1;
        end
        S_ADDR: begin
          // Zeros shift in behind the burst count, so it reads 0 once exhausted.
          addr_sh  <= addr_sh << 1;
          burst_sh <= burst_sh << 1;
          bit_cnt  <= (bit_cnt == ADDR_LAST) ? '0 : bit_cnt + 1'b1;
        end
        S_WAIT_W: if (slave_ready) data_sh <= data_q;
        S_WDATA: begin
          data_sh <= data_sh << 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt  <= '0;
            word_cnt <= word_cnt + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_RDATA: if (rd_word_done) word_cnt <= word_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    approval_request = 1'b0;
    tx_slave_select  = 1'b0;
    tx_address       = 1'b0;
    tx_burst_number  = 1'b0;
    tx_data          = 1'b0;
    master_valid     = 1'b0;
    tx_done          = 1'b0;
    write_en         = 1'b0;
    read_en          = 1'b0;
    case (state)
      S_REQ: approval_request = 1'b1;
      S_SEL: begin
        master_valid    = 1'b1;
        tx_slave_select = sel_sh[SLAVE_LEN-1];
      end
      S_ADDR: begin
        master_valid    = 1'b1;
        tx_address      = addr_sh[ADDR_LEN-1];
        tx_burst_number = burst_sh[BURST_LEN-1];
      end
      S_WDATA: begin
        master_valid = 1'b1;
        tx_data      = data_sh[DATA_LEN-1];
      end
      S_DONE: tx_done = 1'b1;
      default: ;
    endcase
    if (state inside {S_SEL, S_WAIT_ADDR, S_ADDR, S_WAIT_W, S_WDATA, S_RDATA}) begin
      write_en = op_write_q;
      read_en  = !op_write_q;
    end
  end

  bus_master_in #(
    .DATA_LEN(DATA_LEN)
  ) u_in (
    .clk          (clk),
    .reset        (reset),
    .enable       (rd_enable),
    .slave_valid  (slave_valid),
    .rx_data      (rx_data),
    .master_ready (master_ready),
    .word_done    (rd_word_done),
    .new_rx       (new_rx),
    .read_data    (read_data)
  );

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: expected serial bits and read words are queued
// when a command is issued and compared as the DUT emits them.
module tb_bus_master;
  import bus_master_pkg::*;

  localparam int AL = 12;
  localparam int DL = 8;
  localparam int BL = 12;
  localparam int SL = 2;

  logic          clk;
  logic          reset;
  logic [AL-1:0] address;
  logic [DL-1:0] data;
  logic [BL-1:0] burst_num;
  logic [SL-1:0] slave_select;
  logic [1:0]    instruction;
  logic          approval_grant, busy, slave_ready, slave_valid, rx_data;
  logic          approval_request, tx_slave_select, tx_address, tx_burst_number, tx_data;
  logic          master_valid, master_ready, tx_done, write_en, read_en, new_rx;
  logic [DL-1:0] read_data;

  bus_master #(
    .ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(BL), .SLAVE_LEN(SL)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .data(data),
    .burst_num(burst_num), .slave_select(slave_select), .instruction(instruction),
    .approval_grant(approval_grant), .busy(busy), .slave_ready(slave_ready),
    .slave_valid(slave_valid), .rx_data(rx_data),
    .approval_request(approval_request), .tx_slave_select(tx_slave_select),
    .tx_address(tx_address), .tx_burst_number(tx_burst_number), .tx_data(tx_data),
    .master_valid(master_valid), .master_ready(master_ready), .tx_done(tx_done),
    .write_en(write_en), .read_en(read_en), .new_rx(new_rx), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          q_sel[$], q_addr[$], q_burst[$], q_wdata[$], q_rx[$];
  logic [DL-1:0] q_word[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] ctrl_outs();
    return {approval_request, tx_slave_select, tx_address, tx_burst_number, tx_data,
            master_valid, master_ready, tx_done, write_en, read_en, new_rx};
  endfunction

  task automatic push_read_word(input logic [DL-1:0] w);
    for (int i = DL - 1; i >= 0; i--) q_rx.push_back(w[i]);
    q_word.push_back(w);
  endtask

  // Issues a command for one IDLE edge, queues the expected serial bits, then
  // scrambles the inputs to show they were latched.
  task automatic start_cmd(input logic [1:0] op, input logic [SL-1:0] sel,
                           input logic [AL-1:0] addr, input logic [BL-1:0] burst,
                           input logic [DL-1:0] wdata);
    for (int i = SL - 1; i >= 0; i--) q_sel.push_back(sel[i]);
    for (int i = AL - 1; i >= 0; i--) q_addr.push_back(addr[i]);
    for (int i = AL - 1; i >= 0; i--) q_burst.push_back((i >= AL - BL) ? burst[i - (AL - BL)] : 1'b0);
    if (op == INSTR_WRITE)
      for (int w = 0; w <= int'(burst); w++)
        for (int i = DL - 1; i >= 0; i--) q_wdata.push_back(wdata[i]);
    instruction  = op;
    slave_select = sel;
    address      = addr;
    burst_num    = burst;
    data         = wdata;
    tick();
    instruction  = (op == INSTR_WRITE) ? INSTR_READ : INSTR_WRITE;
    slave_select = ~sel;
    address      = ~addr;
    burst_num    = ~burst;
    data         = ~wdata;
    check("req_after_cmd", approval_request, 1'b1);
  endtask

  // Runs a granted transaction to tx_done, checking every cycle.
  task automatic transact(input bit is_write, input int ready_mod, input bit gaps,
                          input int exp_words);
    int  nvalid  = 0;
    int  sent    = 0;
    int  prev    = 0;
    int  n_new   = 0;
    bit  done    = 0;
    bit  hit;
    logic e, eb;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      tick();
      if (cyc == 0) begin
        check("grant_to_sel", master_valid, 1'b1);
        approval_grant = 1'b0;
        busy           = 1'b1;
      end
      hit  = (sent != prev) && (sent % DL == 0);
      prev = sent;
      check("new_rx_timing", new_rx, hit);
      if (new_rx) begin
        n_new++;
        check("read_data", read_data, q_word.size() ? q_word.pop_front() : 'x);
      end
      if (tx_done) begin
        done = 1;
        check("done_enables", {master_valid, write_en, read_en, master_ready}, 4'b0);
        instruction = 2'b00;
      end else begin
        check("write_en", write_en, is_write);
        check("read_en", read_en, !is_write);
        if (master_valid) begin
          if (nvalid < SL) begin
            e = q_sel.size() ? q_sel.pop_front() : 1'bx;
            check("tx_slave_select", tx_slave_select, e);
          end else if (nvalid < SL + AL) begin
            e  = q_addr.size() ? q_addr.pop_front() : 1'bx;
            eb = q_burst.size() ? q_burst.pop_front() : 1'bx;
            check("tx_address", tx_address, e);
            check("tx_burst_number", tx_burst_number, eb);
          end else begin
            e = q_wdata.size() ? q_wdata.pop_front() : 1'bx;
            check("tx_data", tx_data, e);
          end
          nvalid++;
        end
      end
      slave_ready = (ready_mod == 0) ? 1'b1 : (cyc % ready_mod != 0);
      if (master_ready && q_rx.size() > 0 && !(gaps && cyc % 2 == 1)) begin
        slave_valid = 1'b1;
        rx_data     = q_rx.pop_front();
        sent++;
      end else begin
        slave_valid = 1'b0;
        rx_data     = 1'($urandom);
      end
    end
    check("tx_done_seen", done, 1'b1);
    check("queues_drained", q_sel.size() + q_addr.size() + q_burst.size() +
          q_wdata.size() + q_rx.size() + q_word.size(), 0);
    check("new_rx_count", n_new, exp_words);
    slave_ready    = 1'b0;
    slave_valid    = 1'b0;
    approval_grant = 1'b0;
    busy           = 1'b0;
    tick();
    check("idle_after_done", ctrl_outs(), 11'b0);
  endtask

  initial begin
    reset = 1'b0; address = '0; data = '0; burst_num = '0; slave_select = '0;
    instruction = 2'b00; approval_grant = 1'b0; busy = 1'b0;
    slave_ready = 1'b0; slave_valid = 1'b0; rx_data = 1'b0;
    #2;
    check("reset_outs", ctrl_outs(), 11'b0);
    check("reset_read_data", read_data, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    check("idle_outs", ctrl_outs(), 11'b0);

    // No-op codes with the arbiter granting: nothing may happen.
    approval_grant = 1'b1;
    for (int k = 0; k < 6; k++) begin
      instruction = (k < 3) ? 2'b00 : 2'b01;
      tick();
      check("noop_no_request", approval_request, 1'b0);
      check("noop_outs", ctrl_outs(), 11'b0);
    end
    approval_grant = 1'b0;
    instruction    = 2'b00;

    // Single read of one word.
    push_read_word(8'h3C);
    start_cmd(INSTR_READ, 2'b01, 12'hA5C, 12'd0, 8'h00);
    approval_grant = 1'b1;
    transact(1'b0, 0, 1'b0, 1);
    check("single_read_data", read_data, 8'h3C);

    // Burst write of three identical words with a stalling slave_ready.
    start_cmd(INSTR_WRITE, 2'b10, 12'h3F1, 12'd2, 8'h96);
    approval_grant = 1'b1;
    transact(1'b1, 3, 1'b0, 0);

    // Arbitration: grant while busy must hold in REQ.
    start_cmd(INSTR_WRITE, 2'b00, 12'h801, 12'd0, 8'h5A);
    approval_grant = 1'b1;
    busy           = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("arb_request_held", approval_request, 1'b1);
      check("arb_no_tx", master_valid, 1'b0);
    end
    busy = 1'b0;
    transact(1'b1, 0, 1'b0, 0);

    // Two-word read with slave_valid gaps.
    push_read_word(8'hC3);
    push_read_word(8'h5A);
    start_cmd(INSTR_READ, 2'b11, 12'h0F0, 12'd1, 8'h00);
    approval_grant = 1'b1;
    transact(1'b0, 0, 1'b1, 2);
    check("gap_read_data", read_data, 8'h5A);

    // Asynchronous reset in the middle of a write.
    start_cmd(INSTR_WRITE, 2'b10, 12'h123, 12'd3, 8'hFF);
    approval_grant = 1'b1;
    slave_ready    = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check("pre_reset_busy", write_en, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("reset_mid_outs", ctrl_outs(), 11'b0);
    check("reset_mid_read_data", read_data, 8'h00);
    #29;
    check("reset_hold_outs", ctrl_outs(), 11'b0);
    approval_grant = 1'b0;
    slave_ready    = 1'b0;
    instruction    = 2'b00;
    reset          = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_reset_idle", ctrl_outs(), 11'b0);
    end
    q_sel.delete(); q_addr.delete(); q_burst.delete(); q_wdata.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
